// File: rtl/fib_arb_pkg.sv
// Shared state type, widths and range helper for the Fibonacci request arbiter.
package fib_arb_pkg;

    localparam int unsigned FIB_N_W   = 5;
    localparam int unsigned FIB_VAL_W = 16;
    localparam int unsigned FIB_MAX_N = 24;

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StStart,
        StWait,
        StResp
    } fib_state_e;

    // Indices outside 1..FIB_MAX_N never reach the calculator.
    function automatic logic fib_n_in_range(input logic [FIB_N_W-1:0] n);
        return (n != '0) && (32'(n) <= FIB_MAX_N);
    endfunction

endpackage

// File: rtl/fib_rr_arbiter.sv
// Round-robin requester pick: searches from last_grant+1 with wrap, one-hot result.
module fib_rr_arbiter
    import fib_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((32'(last_grant) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fib_arbiter.sv
// Arbitrates Fibonacci requests onto one external calculator and returns the result.
// Define FIB_ARB_TIMEOUT_EN to add a watchdog on the calculator WAIT phase.
module fib_arbiter
    import fib_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    localparam int unsigned ID_W          = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*FIB_N_W-1:0]   req_n,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rsp_valid,
    output logic [ID_W-1:0]              rsp_id,
    output logic [FIB_VAL_W-1:0]         rsp_value,
    output logic                         rsp_err,
    input  logic                         rsp_ready,
    output logic [FIB_N_W-1:0]           calc_n,
    output logic                         calc_reset,
    output logic                         calc_begin,
    input  logic                         calc_done,
    input  logic [FIB_VAL_W-1:0]         calc_value,
    output logic                         busy
);

    fib_state_e             state_q, state_d;
    logic [ID_W-1:0]        last_grant_q, last_grant_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [FIB_N_W-1:0]     n_q, n_d;
    logic [FIB_VAL_W-1:0]   value_q, value_d;
    logic                   err_q, err_d;

    logic [NUM_REQ-1:0]     grant;
    logic [ID_W-1:0]        grant_id;
    logic [FIB_N_W-1:0]     grant_n;

    fib_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        grant_id = '0;
        grant_n  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id = ID_W'(i);
                grant_n  = req_n[i*FIB_N_W +: FIB_N_W];
            end
        end
    end

`ifdef FIB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             timeout;

    // Fires on the last allowed WAIT cycle so RESP follows exactly TIMEOUT_CYCLES later.
    assign timeout = (32'(to_cnt_q) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        n_d          = n_q;
        value_d      = value_q;
        err_d        = err_q;
`ifdef FIB_ARB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (grant != '0) begin
                    last_grant_d = grant_id;
                    id_d         = grant_id;
                    n_d          = grant_n;
                    if (fib_n_in_range(grant_n)) begin
                        state_d = StClr;
                    end else begin
                        value_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StClr: begin
                state_d = StStart;
            end
            StStart: begin
                state_d = StWait;
`ifdef FIB_ARB_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            StWait: begin
                if (calc_done) begin
                    value_d = calc_value;
                    err_d   = 1'b0;
                    state_d = StResp;
`ifdef FIB_ARB_TIMEOUT_EN
                end else if (timeout) begin
                    value_d = '0;
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            n_q          <= '0;
            value_q      <= '0;
            err_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            n_q          <= n_d;
            value_q      <= value_d;
            err_q        <= err_d;
        end
    end

    // Grant is combinational, so it is masked while reset is being applied.
    assign req_ready  = (reset_n && state_q == StIdle) ? grant : '0;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_value  = value_q;
    assign rsp_err    = err_q;
    assign calc_n     = (state_q == StStart || state_q == StWait) ? n_q : '0;
    assign calc_reset = (state_q == StClr);
    assign calc_begin = (state_q == StStart);
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_fib_arbiter.sv
// Self-checking bench for fib_arbiter with a behavioural calculator and reference model.
module tb_fib_arbiter;

    localparam int NR = 4;
    localparam int TO = 64;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [NR*5-1:0] req_n;
    logic [NR-1:0]   req_ready;
    logic            rsp_valid;
    logic [1:0]      rsp_id;
    logic [15:0]     rsp_value;
    logic            rsp_err;
    logic            rsp_ready;
    logic [4:0]      calc_n;
    logic            calc_reset;
    logic            calc_begin;
    logic            calc_done;
    logic [15:0]     calc_value;
    logic            busy;

    always #5 clk = ~clk;

    fib_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_n      (req_n),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_value  (rsp_value),
        .rsp_err    (rsp_err),
        .rsp_ready  (rsp_ready),
        .calc_n     (calc_n),
        .calc_reset (calc_reset),
        .calc_begin (calc_begin),
        .calc_done  (calc_done),
        .calc_value (calc_value),
        .busy       (busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: one in-flight transaction described by its grant cycle and response cycle.
    bit m_active = 0;
    int m_id, m_n, m_g, m_resp, m_val, m_err;
    int m_last = NR - 1;

    // Behavioural calculator.
    int calc_done_at = -1;
    int calc_arg     = 0;
    bit calc_stub    = 0;
    int force_lat    = 0;

    int log_id[$];
    int log_val[$];
    int log_err[$];
    int grant_cyc   = -1;
    int creset_cyc  = -1;
    int cbegin_cyc  = -1;
    int rise_cyc    = -1;
    int begin_count = 0;
    bit prev_rv     = 0;
    int granted     = -1;

    function automatic int fib(int n);
        int a = 0;
        int b = 1;
        int t;
        for (int k = 0; k < n; k++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic bit in_range(int n);
        return (n >= 1) && (n <= 24);
    endfunction

    function automatic int rr_pick(logic [NR-1:0] v, int last);
        for (int k = 1; k <= NR; k++) begin
            if (v[(last + k) % NR]) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        int            p;
        logic [NR-1:0] exp_ready;
        bit            inr, resp_now, accept;
        @(negedge clk);
        exp_ready = '0;
        p = -1;
        if (reset_n && !m_active) begin
            p = rr_pick(req_valid, m_last);
            if (p >= 0) exp_ready[p] = 1'b1;
        end
        inr      = m_active && in_range(m_n);
        resp_now = m_active && (m_resp >= 0) && (cyc >= m_resp);
        if (cyc > 0) begin
            chk("req_ready", int'(req_ready), int'(exp_ready));
            chk("busy", int'(busy), int'(m_active));
            chk("calc_reset", int'(calc_reset), int'(inr && cyc == m_g + 1));
            chk("calc_begin", int'(calc_begin), int'(inr && cyc == m_g + 2));
            chk("rsp_valid", int'(rsp_valid), int'(resp_now));
            if (inr && cyc >= m_g + 2 && !resp_now) chk("calc_n", int'(calc_n), m_n);
            if (resp_now) begin
                chk("rsp_id", int'(rsp_id), m_id);
                chk("rsp_value", int'(rsp_value), m_val);
                chk("rsp_err", int'(rsp_err), m_err);
            end
        end
        if (req_ready != '0) grant_cyc = cyc;
        if (calc_reset) creset_cyc = cyc;
        if (calc_begin) begin
            cbegin_cyc = cyc;
            begin_count++;
        end
        if (rsp_valid && !prev_rv) rise_cyc = cyc;
        prev_rv = rsp_valid;
        granted = -1;
        if (!reset_n) begin
            m_active     = 0;
            m_last       = NR - 1;
            calc_done_at = -1;
        end else begin
            accept = resp_now && rsp_ready;
            if (inr && m_resp < 0) begin
                if (calc_done) begin
                    m_resp = cyc + 1;
                    m_val  = fib(m_n);
                    m_err  = 0;
`ifdef FIB_ARB_TIMEOUT_EN
                end else if (cyc == m_g + 2 + TO) begin
                    m_resp = cyc + 1;
                    m_val  = 0;
                    m_err  = 1;
`endif
                end
            end
            if (accept) begin
                log_id.push_back(int'(rsp_id));
                log_val.push_back(int'(rsp_value));
                log_err.push_back(int'(rsp_err));
                m_active = 0;
            end else if (p >= 0) begin
                m_active = 1;
                m_id     = p;
                m_n      = int'(req_n[p*5 +: 5]);
                m_g      = cyc;
                m_last   = p;
                granted  = p;
                if (in_range(m_n)) begin
                    m_resp = -1;
                end else begin
                    m_resp = cyc + 1;
                    m_val  = 0;
                    m_err  = 1;
                end
            end
            if (calc_reset) calc_done_at = -1;
            if (calc_begin) begin
                calc_arg     = int'(calc_n);
                calc_done_at = calc_stub ? -1 :
                               cyc + ((force_lat > 0) ? force_lat : int'($urandom_range(1, 8)));
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (granted >= 0) req_valid[granted] = 1'b0;
        calc_done  = (cyc == calc_done_at);
        calc_value = calc_done ? 16'(fib(calc_arg)) : 16'($urandom);
    endtask

    task automatic set_req(int i, int n);
        req_valid[i]     = 1'b1;
        req_n[i*5 +: 5]  = 5'(n);
    endtask

    task automatic wait_log(int target, int budget, string what);
        int k = 0;
        while (log_id.size() < target && k < budget) begin
            tick();
            k++;
        end
        chk({what, "_done"}, int'(log_id.size() >= target), 1);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_req_ready"}, int'(req_ready), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_rsp_valid"}, int'(rsp_valid), 0);
        chk({tag, "_rsp_id"}, int'(rsp_id), 0);
        chk({tag, "_rsp_value"}, int'(rsp_value), 0);
        chk({tag, "_rsp_err"}, int'(rsp_err), 0);
        chk({tag, "_calc_n"}, int'(calc_n), 0);
        chk({tag, "_calc_reset"}, int'(calc_reset), 0);
        chk({tag, "_calc_begin"}, int'(calc_begin), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, bc, k;
        reset_n    = 1'b0;
        req_valid  = '0;
        req_n      = '0;
        rsp_ready  = 1'b1;
        calc_done  = 1'b0;
        calc_value = '0;

        // Reset with a request already waiting: nothing may be granted yet.
        set_req(0, 10);
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;

        // Single request, n=10.
        wait_log(1, 40, "single");
        chk("single_clr_lat", creset_cyc - grant_cyc, 1);
        chk("single_begin_lat", cbegin_cyc - grant_cyc, 2);
        chk("single_id", log_id[0], 0);
        chk("single_val", log_val[0], 55);
        chk("single_err", log_err[0], 0);

        // Contention from fresh reset, then rotation past requester 1.
        pulse_reset();
        base = log_id.size();
        set_req(0, 1);
        set_req(1, 2);
        set_req(2, 3);
        set_req(3, 24);
        wait_log(base + 4, 200, "contend");
        chk("contend_id0", log_id[base], 0);
        chk("contend_id1", log_id[base + 1], 1);
        chk("contend_id2", log_id[base + 2], 2);
        chk("contend_id3", log_id[base + 3], 3);
        chk("contend_val0", log_val[base], 1);
        chk("contend_val1", log_val[base + 1], 1);
        chk("contend_val2", log_val[base + 2], 2);
        chk("contend_val3", log_val[base + 3], 46368);
        set_req(1, 5);
        wait_log(base + 5, 40, "rot_first");
        set_req(0, 4);
        set_req(3, 6);
        wait_log(base + 7, 80, "rot");
        chk("rot_id_a", log_id[base + 5], 3);
        chk("rot_val_a", log_val[base + 5], 8);
        chk("rot_id_b", log_id[base + 6], 0);
        chk("rot_val_b", log_val[base + 6], 3);

        // Range errors never start the calculator.
        base = log_id.size();
        bc = begin_count;
        set_req(2, 0);
        wait_log(base + 1, 20, "range0");
        set_req(2, 25);
        wait_log(base + 2, 20, "range25");
        chk("range0_err", log_err[base], 1);
        chk("range0_val", log_val[base], 0);
        chk("range25_err", log_err[base + 1], 1);
        chk("range25_val", log_val[base + 1], 0);
        chk("range_no_begin", begin_count - bc, 0);

        // Backpressure with another requester waiting.
        base = log_id.size();
        rsp_ready = 1'b0;
        set_req(2, 7);
        k = 0;
        while (!rsp_valid && k < 40) begin
            tick();
            k++;
        end
        chk("bp_rsp_seen", int'(rsp_valid), 1);
        set_req(1, 3);
        repeat (5) begin
            tick();
            chk("bp_busy", int'(busy), 1);
            chk("bp_req_ready", int'(req_ready), 0);
            chk("bp_rsp_valid", int'(rsp_valid), 1);
            chk("bp_rsp_value", int'(rsp_value), 13);
        end
        rsp_ready = 1'b1;
        wait_log(base + 2, 40, "bp");
        chk("bp_id_a", log_id[base], 2);
        chk("bp_id_b", log_id[base + 1], 1);
        chk("bp_val_b", log_val[base + 1], 2);

        // Calculator that never finishes.
        base = log_id.size();
        calc_stub = 1;
        set_req(0, 12);
`ifdef FIB_ARB_TIMEOUT_EN
        wait_log(base + 1, TO + 20, "timeout");
        chk("timeout_err", log_err[base], 1);
        chk("timeout_val", log_val[base], 0);
        chk("timeout_lat", rise_cyc - cbegin_cyc, TO + 1);
        calc_stub = 0;
        // done arriving on the timeout cycle itself wins.
        force_lat = TO;
        set_req(0, 12);
        wait_log(base + 2, TO + 20, "to_race");
        chk("to_race_err", log_err[base + 1], 0);
        chk("to_race_val", log_val[base + 1], 144);
        force_lat = 0;
`else
        repeat (150) tick();
        chk("stall_busy", int'(busy), 1);
        chk("stall_rsp_valid", int'(rsp_valid), 0);
        chk("stall_no_rsp", log_id.size(), base);
        calc_stub = 0;
        pulse_reset();
`endif

        // Reset while waiting on the calculator, then recover.
        force_lat = 30;
        bc = begin_count;
        set_req(1, 9);
        k = 0;
        while (begin_count == bc && k < 20) begin
            tick();
            k++;
        end
        repeat (3) tick();
        chk("rw_in_wait", int'(busy), 1);
        pulse_reset();
        chk_all_zero("rst_wait");
        force_lat = 0;
        base = log_id.size();
        set_req(1, 5);
        wait_log(base + 1, 40, "after_rst");
        chk("after_rst_val", log_val[base], 5);
        chk("after_rst_err", log_err[base], 0);
        chk("after_rst_clr", creset_cyc - grant_cyc, 1);

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && ($urandom % 4 == 0)) begin
                    set_req(i, ($urandom % 8 == 0) ? int'($urandom % 32)
                                                   : int'($urandom_range(1, 24)));
                end else if (req_valid[i] && ($urandom % 16 == 0)) begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = ($urandom % 3 != 0);
            reset_n   = ($urandom % 300 != 0);
            tick();
        end
        reset_n   = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        k = 0;
        while (busy && k < 100) begin
            tick();
            k++;
        end
        chk("drain_idle", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fib_arbiter.md
FIB_ARBITER -- requirements
Module: fib_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: watchdog limit for each calculator run.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester request.
REQ-006 SHALL have port req_n, input, NUM_REQ*5 bits: per-requester Fibonacci index, slice i = bits [5i+4:5i].
REQ-007 SHALL have port req_ready, output, NUM_REQ bits: one-hot grant/accept.
REQ-008 SHALL have port rsp_valid, output, 1 bit: response valid.
REQ-009 SHALL have port rsp_id, output, $clog2(NUM_REQ) bits: the served requester.
REQ-010 SHALL have port rsp_value, output, 16 bits: the Fibonacci result.
REQ-011 SHALL have port rsp_err, output, 1 bit: range-error or timeout flag.
REQ-012 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-013 SHALL have port calc_n, output, 5 bits: index driven to the calculator.
REQ-014 SHALL have port calc_reset, output, 1 bit: active-high calculator clear.
REQ-015 SHALL have port calc_begin, output, 1 bit: one-cycle calculator start.
REQ-016 SHALL have port calc_done, input, 1 bit: calculator finished.
REQ-017 SHALL have port calc_value, input, 16 bits: calculator result.
REQ-018 SHALL have port busy, output, 1 bit: asserted whenever the state is not IDLE.

Function
REQ-019 SHALL implement the states IDLE, CLR, START, WAIT and RESP.
REQ-020 In IDLE, SHALL grant round-robin, searching from last_grant+1 with wrap; req_ready[i] SHALL be asserted combinationally in the grant cycle only; at most one bit set.
REQ-021 On grant, SHALL latch the index and id and update last_grant.
REQ-022 An index of 1..24 SHALL go to CLR.
REQ-023 An index of 0 or 25..31 SHALL go directly to RESP with rsp_err=1 and rsp_value=0; calc_reset and calc_begin SHALL not assert for that request.
REQ-024 CLR (grant+1) SHALL assert calc_reset=1 for exactly one cycle.
REQ-025 START (grant+2) SHALL assert calc_begin=1 for exactly one cycle.
REQ-026 calc_n SHALL hold the latched index from START through the end of WAIT.
REQ-027 In WAIT, calc_done=1 SHALL capture calc_value into rsp_value, set rsp_err=0 and go to RESP; rsp_valid SHALL rise the next cycle.
REQ-028 In RESP, rsp_valid, rsp_id, rsp_value and rsp_err SHALL stay stable until rsp_valid & rsp_ready; then the block SHALL go to IDLE and rsp_valid SHALL drop.
REQ-029 No grant SHALL occur in the cycle a response is accepted; the earliest next grant is the following cycle.
REQ-030 A requester SHALL hold req_valid and req_n until its req_ready; a deasserted request SHALL drop out of arbitration with no error.
REQ-031 Results SHALL satisfy F(1)=F(2)=1; F(24)=46368 is the largest value that fits 16 bits.

Reset
REQ-032 While reset_n=0 at a clock edge, the state SHALL become IDLE and last_grant SHALL become NUM_REQ-1, so requester 0 has first priority.
REQ-033 Reset SHALL drive all outputs to 0, including req_ready, rsp_*, calc_* and busy.
REQ-034 Reset in any state SHALL abort the operation and discard any pending response.
REQ-035 The first request after reset SHALL still pass through CLR.

Configuration
REQ-036 SHALL support the macro FIB_ARB_TIMEOUT_EN.
REQ-037 When FIB_ARB_TIMEOUT_EN is defined: a counter SHALL clear on entering WAIT; after TIMEOUT_CYCLES WAIT cycles with no calc_done, the block SHALL go to RESP with rsp_err=1 and rsp_value=0.
REQ-038 A calc_done in the same cycle as the timeout SHALL take priority over the timeout.
REQ-039 When FIB_ARB_TIMEOUT_EN is not defined: no counter SHALL exist, WAIT SHALL wait indefinitely, and rsp_err SHALL flag range errors only.

Structure
REQ-040 Package fib_arb_pkg SHALL hold the state enum, FIB_N_W=5, FIB_VAL_W=16 and FIB_MAX_N=24.
REQ-041 Round-robin grant logic SHALL be in sub-module fib_rr_arbiter, with inputs req and last_grant and output one-hot grant.
REQ-042 fib_arbiter SHALL instantiate one fib_rr_arbiter and connect the calc_* ports to one fibonacci_calculator in the parent.

Verification
REQ-043 Single request: req0 with n=10 -> grant at T, calc_reset at T+1, calc_begin at T+2, then rsp_id=0, rsp_value=55, rsp_err=0.
REQ-044 Contention: all four request with n=1,2,3,24 -> served in order 0,1,2,3 with values 1,1,2,46368; next, with req0 and req3 pending after serving 1 -> 3 is served before 0.
REQ-045 Range error: n=0, then n=25 -> each gives rsp_err=1 and rsp_value=0; calc_begin never asserts.
REQ-046 Backpressure: rsp_ready held low for 5 cycles -> rsp_* stable, no req_ready asserted, busy=1.
REQ-047 Timeout: calc_done stubbed to 0 -> with FIB_ARB_TIMEOUT_EN, rsp_err=1 after 64 WAIT cycles; without it, the block remains in WAIT.
REQ-048 Reset in WAIT: all outputs are 0 the next cycle; a subsequent request with n=5 returns 5.
